// File: rtl/vertex_rmw_pipe_pkg.sv
// Shared definitions for the vertex read-modify-write pipeline.
// - ADDR_W_DEF / DATA_W_DEF : default vertex address and value widths
// - COMBINE_ADD / COMBINE_MIN : selector values for the combine operation
// - stage_t : one pipeline stage record {valid, address, data} at default widths
package vertex_rmw_pipe_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  localparam bit COMBINE_ADD = 1'b0;
  localparam bit COMBINE_MIN = 1'b1;

  typedef struct packed {
    logic                  v;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/vertex_ram.sv
// Simple dual-port vertex value memory.
// - Port A (rd_addr -> rd_data): read-only, registered read, one cycle latency.
// - Port B (we, wr_addr, wr_data): write port with write-first behaviour: a
//   read of the address being written in the same cycle returns the new data.
// Ports:
//   clk      in   single clock
//   rd_addr  in   port A read address
//   rd_data  out  port A registered read data
//   we       in   port B write enable
//   wr_addr  in   port B write address
//   wr_data  in   port B write data
module vertex_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    // A read racing a write to the same word sees the value being committed,
    // so a consumer released in the write cycle never observes stale data.
    if (we && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vertex_rmw_pipe.sv
// Read-modify-write stage feeding the hazard detection unit (HDU).
// Each accepted update (addr, value) is issued to the HDU on Raddr, the old
// vertex value is read from local memory, combined with the update (wrapping
// add or unsigned min, chosen by OP_MIN), and written back; the write-back is
// reported on Waddr so the HDU can release its lock.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   upd_valid/addr/value      update offer
//   upd_ready                 update accepted when upd_valid && upd_ready
//   stall_signal              HDU stall: holds the issue stage
//   Raddr, Raddr_valid        issue-stage address to the HDU
//   Waddr, Waddr_valid        write-back address to the HDU
//   init_wr/addr/data         host preload write (only while idle)
//   idle                      nothing held, in flight or offered
module vertex_rmw_pipe
  import vertex_rmw_pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit OP_MIN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_value,
  output logic              upd_ready,
  input  logic              stall_signal,
  output logic [ADDR_W-1:0] Raddr,
  output logic              Raddr_valid,
  output logic [ADDR_W-1:0] Waddr,
  output logic              Waddr_valid,
  input  logic              init_wr,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              idle
);

  function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] old_val,
                                                input logic [DATA_W-1:0] upd_val);
    case (OP_MIN)
      COMBINE_MIN: combine = (upd_val < old_val) ? upd_val : old_val;
      COMBINE_ADD: combine = old_val + upd_val;
    endcase
  endfunction

  logic              rst_q;
  logic              accept;

  logic              vld_p0, vld_p1, vld_p2, vld_p3;
  logic [ADDR_W-1:0] addr_p0, addr_p1, addr_p2, addr_p3;
  logic [DATA_W-1:0] upd_p0, upd_p1;
  logic [DATA_W-1:0] rd_p1;
  logic [DATA_W-1:0] data_p2, data_p3;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;

  assign upd_ready = ~stall_signal & ~rst_q;
  assign accept    = upd_valid & upd_ready;

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // S0: issue register, held while the HDU stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      upd_p0  <= '0;
    end else if (!stall_signal) begin
      vld_p0 <= accept;
      if (accept) begin
        addr_p0 <= upd_addr;
        upd_p0  <= upd_value;
      end
    end
  end

  // S1: memory read data (registered inside vertex_ram); bubble while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      upd_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0 & ~stall_signal;
      if (!stall_signal) begin
        addr_p1 <= addr_p0;
        upd_p1  <= upd_p0;
      end
    end
  end

  // S2: combine result; S2 and S3 keep moving during a stall so the write
  // that the HDU is waiting on still drains
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      addr_p2 <= addr_p1;
      data_p2 <= combine(rd_p1, upd_p1);
    end
  end

  // S3: write-back to memory port B and report to the HDU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      addr_p3 <= '0;
      data_p3 <= '0;
    end else begin
      vld_p3  <= vld_p2;
      addr_p3 <= addr_p2;
      data_p3 <= data_p2;
    end
  end

  // Host preload shares port B and loses to a pipeline write.
  assign ram_we      = vld_p3 | init_wr;
  assign ram_wr_addr = vld_p3 ? addr_p3 : init_addr;
  assign ram_wr_data = vld_p3 ? data_p3 : init_data;

  vertex_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (addr_p0),
    .rd_data (rd_p1),
    .we      (ram_we),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data)
  );

  assign Raddr       = addr_p0;
  assign Raddr_valid = vld_p0;
  assign Waddr       = addr_p3;
  assign Waddr_valid = vld_p3;
  assign idle        = ~(vld_p0 | vld_p1 | vld_p2 | vld_p3) & ~upd_valid;

  init_wr_while_writing: assert property (@(posedge clk) disable iff (rst) !(init_wr && vld_p3));

endmodule

// File: tb/tb_vertex_rmw_pipe.sv
module tb_vertex_rmw_pipe;
  import vertex_rmw_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic [15:0] upd_addr;
  logic [31:0] upd_value;
  logic        stall;
  logic        init_wr;
  logic [15:0] init_addr;
  logic [31:0] init_data;

  logic        ready_a, rv_a, wv_a, idle_a;
  logic [15:0] raddr_a, waddr_a;
  logic        ready_m, rv_m, wv_m, idle_m;
  logic [15:0] raddr_m, waddr_m;

  vertex_rmw_pipe #(.ADDR_W(16), .DATA_W(32), .OP_MIN(1'b0)) dut_add (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_value(upd_value),
    .upd_ready(ready_a), .stall_signal(stall), .Raddr(raddr_a), .Raddr_valid(rv_a),
    .Waddr(waddr_a), .Waddr_valid(wv_a), .init_wr(init_wr), .init_addr(init_addr),
    .init_data(init_data), .idle(idle_a));

  vertex_rmw_pipe #(.ADDR_W(16), .DATA_W(32), .OP_MIN(1'b1)) dut_min (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_value(upd_value),
    .upd_ready(ready_m), .stall_signal(stall), .Raddr(raddr_m), .Raddr_valid(rv_m),
    .Waddr(waddr_m), .Waddr_valid(wv_m), .init_wr(init_wr), .init_addr(init_addr),
    .init_data(init_data), .idle(idle_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int wcount = 0;

  // Reference memories: add-mode and min-mode views of the same vertices.
  logic [31:0] ref_add [int];
  logic [31:0] ref_min [int];
  // Accepted updates not yet written back, in acceptance order.
  stage_t pend_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [31:0] obs_a, input logic [31:0] obs_m,
                        input logic [31:0] exp);
    check({tag, "_add"}, obs_a, exp);
    check({tag, "_min"}, obs_m, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    init_wr   = 1'b1;
    init_addr = a;
    init_data = d;
    tick();
    init_wr = 1'b0;
    ref_add[int'(a)] = d;
    ref_min[int'(a)] = d;
  endtask

  task automatic send_one(input logic [15:0] a, input logic [31:0] v);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_value = v;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [15:0] a);
    check({tag, "_mem_add"}, dut_add.u_ram.mem[a], ref_add[int'(a)]);
    check({tag, "_mem_min"}, dut_min.u_ram.mem[a], ref_min[int'(a)]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(idle_a && idle_m) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_reached"}, {31'd0, idle_a & idle_m}, 32'd1);
  endtask

  // Scoreboard: record accepts, retire them on each write-back pulse.
  always @(negedge clk) begin
    stage_t e;
    if (!rst && upd_valid && ready_a) begin
      e.v = 1'b1;
      e.addr = upd_addr;
      e.data = upd_value;
      pend_q.push_back(e);
    end
    if (wv_a || wv_m) begin
      wcount++;
      if (pend_q.size() == 0) begin
        check("waddr_unexpected", {30'd0, wv_a, wv_m}, 32'd0);
      end else begin
        e = pend_q.pop_front();
        check("waddr_add", {16'd0, waddr_a}, {16'd0, e.addr});
        check("waddr_min", {16'd0, waddr_m}, {16'd0, e.addr});
        check("wvalid_both", {31'd0, wv_a & wv_m}, 32'd1);
        ref_add[int'(e.addr)] = ref_add[int'(e.addr)] + e.data;
        if (e.data < ref_min[int'(e.addr)]) ref_min[int'(e.addr)] = e.data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hist [$];
    logic [31:0] keep21;
    int w0;
    int naccept;
    bit pending;
    bit hit;
    logic [15:0] cand;

    rst = 1'b1; upd_valid = 1'b0; upd_addr = '0; upd_value = '0;
    stall = 1'b0; init_wr = 1'b0; init_addr = '0; init_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // first cycle after reset
    check2("rst_ready", ready_a, ready_m, 32'd0);
    check2("rst_rvalid", rv_a, rv_m, 32'd0);
    check2("rst_wvalid", wv_a, wv_m, 32'd0);
    check2("rst_idle", idle_a, idle_m, 32'd1);
    check2("rst_raddr", raddr_a, raddr_m, 32'd0);
    tick();
    check2("post_rst_ready", ready_a, ready_m, 32'd1);

    // single update
    preload(16'd5, 32'd10);
    w0 = wcount;
    send_one(16'd5, 32'd3);
    check2("t1_rvalid", rv_a, rv_m, 32'd1);
    check2("t1_raddr", raddr_a, raddr_m, 32'd5);
    tick(); tick();
    check2("t1_wvalid_early", wv_a, wv_m, 32'd0);
    tick();
    check2("t1_wvalid", wv_a, wv_m, 32'd1);
    check2("t1_waddr", waddr_a, waddr_m, 32'd5);
    check2("t1_busy", idle_a, idle_m, 32'd0);
    tick();
    check("t1_mem_add_13", dut_add.u_ram.mem[5], 32'd13);
    check("t1_mem_min_3", dut_min.u_ram.mem[5], 32'd3);
    check2("t1_idle", idle_a, idle_m, 32'd1);
    check("t1_pulses", wcount - w0, 32'd1);

    // back-to-back same address, HDU stalls two cycles
    preload(16'd7, 32'd0);
    w0 = wcount;
    upd_valid = 1'b1; upd_addr = 16'd7; upd_value = 32'd1;
    tick();
    check2("t2_ready_second", ready_a, ready_m, 32'd1);
    tick();
    upd_valid = 1'b0;
    stall = 1'b1;
    #1;
    check2("t2_stall_ready_c2", ready_a, ready_m, 32'd0);
    check2("t2_stall_raddr_c2", raddr_a, raddr_m, 32'd7);
    check2("t2_stall_rvalid_c2", rv_a, rv_m, 32'd1);
    tick();
    check2("t2_stall_ready_c3", ready_a, ready_m, 32'd0);
    check2("t2_stall_raddr_c3", raddr_a, raddr_m, 32'd7);
    check2("t2_stall_rvalid_c3", rv_a, rv_m, 32'd1);
    check2("t2_wvalid_c3", wv_a, wv_m, 32'd0);
    tick();
    stall = 1'b0;
    check2("t2_first_write", wv_a, wv_m, 32'd1);
    check2("t2_held_rvalid", rv_a, rv_m, 32'd1);
    check2("t2_held_raddr", raddr_a, raddr_m, 32'd7);
    tick();
    check2("t2_rvalid_drop", rv_a, rv_m, 32'd0);
    tick(); tick();
    check2("t2_second_write", wv_a, wv_m, 32'd1);
    check2("t2_second_waddr", waddr_a, waddr_m, 32'd7);
    tick();
    check("t2_mem_add_2", dut_add.u_ram.mem[7], 32'd2);
    check("t2_mem_min_0", dut_min.u_ram.mem[7], 32'd0);
    check("t2_pulses", wcount - w0, 32'd2);

    // min sequence, spaced so no hazard arises
    preload(16'd9, 32'd50);
    w0 = wcount;
    send_one(16'd9, 32'd40); repeat (4) tick();
    send_one(16'd9, 32'd60); repeat (4) tick();
    send_one(16'd9, 32'd30); repeat (4) tick();
    check("t3_mem_min_30", dut_min.u_ram.mem[9], 32'd30);
    check("t3_mem_add_180", dut_add.u_ram.mem[9], 32'd180);
    check("t3_pulses", wcount - w0, 32'd3);

    // wrap-around add
    preload(16'd1, 32'hFFFF_FFFF);
    send_one(16'd1, 32'd2); repeat (4) tick();
    check("t4_wrap_add", dut_add.u_ram.mem[1], 32'd1);
    check("t4_wrap_min", dut_min.u_ram.mem[1], 32'd2);

    // stream of 64 distinct addresses, no stall
    for (int i = 0; i < 64; i++) preload(16'(100 + i), $urandom);
    w0 = wcount;
    for (int i = 0; i < 64; i++) begin
      upd_valid = 1'b1;
      upd_addr  = 16'(100 + i);
      upd_value = $urandom;
      #1;
      check2("t5_ready", ready_a, ready_m, 32'd1);
      tick();
      check2("t5_raddr", raddr_a, raddr_m, 32'(100 + i));
    end
    upd_valid = 1'b0;
    tick(); tick(); tick();
    check2("t5_busy_tail", idle_a, idle_m, 32'd0);
    tick();
    check2("t5_idle", idle_a, idle_m, 32'd1);
    check("t5_pulses", wcount - w0, 32'd64);
    for (int i = 0; i < 64; i++) check_mem("t5", 16'(100 + i));

    // reset while all four stages are full
    for (int i = 20; i < 24; i++) preload(16'(i), $urandom_range(1000));
    keep21 = ref_add[21];
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1;
      upd_addr  = 16'(20 + i);
      upd_value = 32'(i + 1);
      tick();
    end
    upd_valid = 1'b0;
    check2("t6_full_rvalid", rv_a, rv_m, 32'd1);
    check2("t6_full_wvalid", wv_a, wv_m, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend_q.delete();
    check2("t6_rvalid", rv_a, rv_m, 32'd0);
    check2("t6_wvalid", wv_a, wv_m, 32'd0);
    check2("t6_ready", ready_a, ready_m, 32'd0);
    check2("t6_idle", idle_a, idle_m, 32'd1);
    check2("t6_waddr", waddr_a, waddr_m, 32'd0);
    w0 = wcount;
    repeat (6) tick();
    check("t6_no_waddr", wcount - w0, 32'd0);
    check("t6_mem21_kept", dut_add.u_ram.mem[21], keep21);
    for (int i = 20; i < 24; i++) check_mem("t6", 16'(i));
    check_mem("t6_old5", 16'd5);
    check_mem("t6_old7", 16'd7);
    check_mem("t6_old9", 16'd9);

    // randomized traffic with random stalls; an address is not reused
    // within four accepts, which is the spacing an HDU would enforce
    for (int i = 200; i < 216; i++) preload(16'(i), $urandom);
    w0 = wcount;
    naccept = 0;
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && ($urandom_range(3) != 0)) begin
        do begin
          cand = 16'(200 + $urandom_range(15));
          hit = 1'b0;
          foreach (hist[k]) if (hist[k] == cand) hit = 1'b1;
        end while (hit);
        upd_addr  = cand;
        upd_value = $urandom;
        upd_valid = 1'b1;
        pending   = 1'b1;
      end
      stall = ($urandom_range(3) == 0);
      #1;
      if (upd_valid && ready_a) begin
        hist.push_back(upd_addr);
        if (hist.size() > 4) void'(hist.pop_front());
        pending = 1'b0;
        naccept++;
      end
      tick();
      if (!pending) upd_valid = 1'b0;
    end
    upd_valid = 1'b0;
    stall = 1'b0;
    wait_idle("t7", 20);
    tick();
    check("t7_pending_empty", pend_q.size(), 32'd0);
    check("t7_pulses", wcount - w0, naccept);
    for (int i = 200; i < 216; i++) check_mem("t7", 16'(i));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
